pool_window_gather: RTL

- Upstream neighbour of maxPooling.
- Accepts a raster-scan stream of 22-bit feature-map values, one per cycle, from the convolution stage.
- Buffers one row and emits each non-overlapping 2x2 window as four parallel words plus a valid strobe.
- Those outputs drive maxPooling's input1..input4 and enable directly.

---
 rtl/pool_window_gather_pkg.sv | 15 +
 rtl/pool_window_gather_line_buffer.sv | 35 +++
 rtl/pool_window_gather.sv | 102 ++++++++++
 3 files changed

// File: rtl/pool_window_gather_pkg.sv
// Shared definitions for the 2x2 pooling window gatherer.
//   POOL_DATA_W     : feature-map word width, shared with maxPooling
//   POOL_IMG_W/H    : default frame geometry
//   cnt_w()         : counter width for a 0..n-1 counter (minimum 1 bit)
package pool_window_gather_pkg;

  localparam int POOL_DATA_W = 22;
  localparam int POOL_IMG_W  = 4;
  localparam int POOL_IMG_H  = 4;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_window_gather_line_buffer.sv
// One-row line buffer holding the even row of a window pair.
//   clk        : clock
//   wr_en      : write wr_data at wr_addr on the rising edge
//   wr_addr    : column being written
//   wr_data    : pixel value
//   rd_addr_a  : left column of the window (col_cnt-1)
//   rd_addr_b  : right column of the window (col_cnt)
//   rd_data_a/b: combinational read data
// Deliberately has no reset: every entry is rewritten on an even row before
// the following odd row reads it, so this can later map onto a plain RAM.
module pool_line_buffer #(
  parameter int DATA_W = 22,
  parameter int IMG_W  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem [IMG_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/pool_window_gather.sv
// Gathers non-overlapping 2x2 windows from a raster-scan pixel stream and
// presents them as four registered words plus a one-cycle valid strobe.
//   clk, reset      : clock, synchronous active-high reset
//   in_valid/in_data: accepted pixel stream, row-major order
//   win_valid       : one-cycle strobe per window (maxPooling enable)
//   win_tl/tr/bl/br : window words (maxPooling input1..input4)
//   frame_done      : pulses together with the last window of a frame
module pool_window_gather
  import pool_window_gather_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int IMG_W  = POOL_IMG_W,
  parameter int IMG_H  = POOL_IMG_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              win_valid,
  output logic [DATA_W-1:0] win_tl,
  output logic [DATA_W-1:0] win_tr,
  output logic [DATA_W-1:0] win_bl,
  output logic [DATA_W-1:0] win_br,
  output logic              frame_done
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);

  if ((IMG_W < 2) || (IMG_W % 2 != 0) || (IMG_H < 2) || (IMG_H % 2 != 0)) begin : g_bad_geometry
    $error("pool_window_gather: IMG_W and IMG_H must be even and at least 2");
  end

  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] lb_left;
  logic [DATA_W-1:0] lb_right;
  logic              last_col;
  logic              last_row;
  logic              odd_row;
  logic              odd_col;

  assign last_col = (col_cnt == CW'(IMG_W - 1));
  assign last_row = (row_cnt == RW'(IMG_H - 1));
  assign odd_row  = row_cnt[0];
  assign odd_col  = col_cnt[0];

  // Reset gates the write so a reset cycle never changes any state.
  pool_line_buffer #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .AW     (CW)
  ) u_line_buffer (
    .clk       (clk),
    .wr_en     (in_valid && !reset && !odd_row),
    .wr_addr   (col_cnt),
    .wr_data   (in_data),
    .rd_addr_a (col_cnt - CW'(1)),
    .rd_addr_b (col_cnt),
    .rd_data_a (lb_left),
    .rd_data_b (lb_right)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      hold_reg   <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_tl     <= '0;
      win_tr     <= '0;
      win_bl     <= '0;
      win_br     <= '0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (odd_row) begin
          if (odd_col) begin
            win_tl     <= lb_left;
            win_tr     <= lb_right;
            win_bl     <= hold_reg;
            win_br     <= in_data;
            win_valid  <= 1'b1;
            frame_done <= last_row && last_col;
          end else begin
            hold_reg <= in_data;
          end
        end
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_row ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
    end
  end

endmodule
